// File: rtl/arp_tx.sv
// -----------------------------------------------------------------------------
// arp_tx -- ARP request/reply frame generator (32-bit stream, arbiter handshake)
//
// Builds an ARP payload (Ethernet/IPv4, 28 bytes = 7 words) from the local
// MAC/IP plus the fields captured with a request or reply trigger. It then
// requests the shared TX path from an arbiter and streams the words out with
// valid/ready flow control.
//
// Ports:
//   clk_user_i          user clock, rising edge
//   reset_i             asynchronous active-high reset
//   our_mac_i/our_ip_i  local SHA / SPA
//   req_start_i         pulse: send request for req_tpa_i
//   rpl_start_i         pulse: send reply to rpl_tha_i / rpl_tpa_i
//   tx_arp_req_o        registered arbiter request (ARB and SEND)
//   tx_arp_gnt_i        arbiter grant, only looked at in ARB
//   tx_arp_data_*       payload stream (wld/ready/data/be/tlast)
//   busy_o              state is not IDLE
//   done_o              one-cycle pulse after the last word is accepted
//
// Build option: define ARP_TX_PAD_EN to pad the frame with zero words up to
// the 46-byte Ethernet minimum payload (12 words, last word has be=1100).
// -----------------------------------------------------------------------------
module arp_tx (
    input  logic        clk_user_i,
    input  logic        reset_i,
    input  logic [47:0] our_mac_i,
    input  logic [31:0] our_ip_i,
    input  logic        req_start_i,
    input  logic [31:0] req_tpa_i,
    input  logic        rpl_start_i,
    input  logic [47:0] rpl_tha_i,
    input  logic [31:0] rpl_tpa_i,
    output logic        tx_arp_req_o,
    input  logic        tx_arp_gnt_i,
    output logic        tx_arp_data_wld_o,
    input  logic        tx_arp_data_ready_i,
    output logic [31:0] tx_arp_data_o,
    output logic [3:0]  tx_arp_data_be_o,
    output logic        tx_arp_data_tlast_o,
    output logic        busy_o,
    output logic        done_o
);

`ifdef ARP_TX_PAD_EN
    localparam logic [3:0] LAST_IDX = 4'd11;
`else
    localparam logic [3:0] LAST_IDX = 4'd6;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg, state_next;

    // one-deep pending triggers
    logic        req_pend_reg;
    logic [31:0] req_tpa_reg;
    logic        rpl_pend_reg;
    logic [47:0] rpl_tha_reg;
    logic [31:0] rpl_tpa_reg;

    // frame register, frozen for the whole frame
    logic        frm_is_rpl_reg;
    logic [47:0] frm_sha_reg;
    logic [31:0] frm_spa_reg;
    logic [47:0] frm_tha_reg;
    logic [31:0] frm_tpa_reg;

    logic [3:0]  idx_reg;
    logic        req_out_reg;

    logic        sel_rpl;
    logic        sel_req;
    logic        beat;
    logic        last_word;
    logic        in_send;
    logic [31:0] word_sel;

    // Reply has priority; the request stays pending and goes after DONE.
    assign sel_rpl   = (state_reg == IDLE) && rpl_pend_reg;
    assign sel_req   = (state_reg == IDLE) && req_pend_reg && !rpl_pend_reg;
    assign in_send   = (state_reg == SEND);
    assign beat      = in_send && tx_arp_data_ready_i;
    assign last_word = (idx_reg == LAST_IDX);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_user_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        tx_arp_data_wld_o = 1'b0;
        busy_o            = (state_reg != IDLE);
        done_o            = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rpl_pend_reg || req_pend_reg) begin
                    state_next = ARB;
                end
            end
            ARB: begin
                if (tx_arp_gnt_i) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                tx_arp_data_wld_o = 1'b1;
                if (beat && last_word) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered arbiter request: high from ARB entry through SEND.
    always_ff @(posedge clk_user_i or posedge reset_i) begin
        if (reset_i) begin
            req_out_reg <= 1'b0;
        end else begin
            req_out_reg <= (state_next == ARB) || (state_next == SEND);
        end
    end
    assign tx_arp_req_o = req_out_reg;

    // ------------------------------------------------------ pending triggers
    // A new pulse always wins over the clear-on-select so it is never lost.
    always_ff @(posedge clk_user_i or posedge reset_i) begin
        if (reset_i) begin
            req_pend_reg <= 1'b0;
            req_tpa_reg  <= '0;
            rpl_pend_reg <= 1'b0;
            rpl_tha_reg  <= '0;
            rpl_tpa_reg  <= '0;
        end else begin
            if (req_start_i) begin
                req_pend_reg <= 1'b1;
                req_tpa_reg  <= req_tpa_i;
            end else if (sel_req) begin
                req_pend_reg <= 1'b0;
            end
            if (rpl_start_i) begin
                rpl_pend_reg <= 1'b1;
                rpl_tha_reg  <= rpl_tha_i;
                rpl_tpa_reg  <= rpl_tpa_i;
            end else if (sel_rpl) begin
                rpl_pend_reg <= 1'b0;
            end
        end
    end

    // --------------------------------------------------------- frame register
    always_ff @(posedge clk_user_i or posedge reset_i) begin
        if (reset_i) begin
            frm_is_rpl_reg <= 1'b0;
            frm_sha_reg    <= '0;
            frm_spa_reg    <= '0;
            frm_tha_reg    <= '0;
            frm_tpa_reg    <= '0;
        end else if (sel_rpl || sel_req) begin
            frm_is_rpl_reg <= sel_rpl;
            frm_sha_reg    <= our_mac_i;
            frm_spa_reg    <= our_ip_i;
            frm_tha_reg    <= sel_rpl ? rpl_tha_reg : 48'd0;
            frm_tpa_reg    <= sel_rpl ? rpl_tpa_reg : req_tpa_reg;
        end
    end

    // ------------------------------------------------------------ word index
    // Advances only on accepted beats, so data/be/tlast hold during stalls.
    always_ff @(posedge clk_user_i or posedge reset_i) begin
        if (reset_i) begin
            idx_reg <= '0;
        end else if (beat) begin
            idx_reg <= last_word ? 4'd0 : idx_reg + 4'd1;
        end
    end

    // ------------------------------------------------------------ word mux
    // Pad words (index 7 and up) fall to the zero default.
    always_comb begin
        word_sel = '0;
        case (idx_reg)
            4'd0: word_sel = 32'h0001_0800;
            4'd1: word_sel = {16'h0604, 14'd0, frm_is_rpl_reg, ~frm_is_rpl_reg};
            4'd2: word_sel = frm_sha_reg[47:16];
            4'd3: word_sel = {frm_sha_reg[15:0], frm_spa_reg[31:16]};
            4'd4: word_sel = {frm_spa_reg[15:0], frm_tha_reg[47:32]};
            4'd5: word_sel = frm_tha_reg[31:0];
            4'd6: word_sel = frm_tpa_reg;
            default: word_sel = '0;
        endcase
    end

    assign tx_arp_data_o       = in_send ? word_sel : 32'd0;
    assign tx_arp_data_tlast_o = in_send && last_word;

`ifdef ARP_TX_PAD_EN
    // 46 bytes = 11 full words + 2 bytes: final word carries only [31:16].
    assign tx_arp_data_be_o = !in_send  ? 4'b0000 :
                              last_word ? 4'b1100 : 4'b1111;
`else
    assign tx_arp_data_be_o = in_send ? 4'b1111 : 4'b0000;
`endif

endmodule

// File: tb/tb_arp_tx.sv
module tb_arp_tx;

`ifdef ARP_TX_PAD_EN
    localparam int NW = 12;
    localparam logic [3:0] LAST_BE = 4'b1100;
`else
    localparam int NW = 7;
    localparam logic [3:0] LAST_BE = 4'b1111;
`endif

    logic        clk;
    logic        rst;
    logic [47:0] our_mac;
    logic [31:0] our_ip;
    logic        req_start;
    logic [31:0] req_tpa;
    logic        rpl_start;
    logic [47:0] rpl_tha;
    logic [31:0] rpl_tpa;
    logic        req_o;
    logic        gnt;
    logic        wld;
    logic        ready;
    logic [31:0] data;
    logic [3:0]  be;
    logic        tlast;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    arp_tx dut (
        .clk_user_i          (clk),
        .reset_i             (rst),
        .our_mac_i           (our_mac),
        .our_ip_i            (our_ip),
        .req_start_i         (req_start),
        .req_tpa_i           (req_tpa),
        .rpl_start_i         (rpl_start),
        .rpl_tha_i           (rpl_tha),
        .rpl_tpa_i           (rpl_tpa),
        .tx_arp_req_o        (req_o),
        .tx_arp_gnt_i        (gnt),
        .tx_arp_data_wld_o   (wld),
        .tx_arp_data_ready_i (ready),
        .tx_arp_data_o       (data),
        .tx_arp_data_be_o    (be),
        .tx_arp_data_tlast_o (tlast),
        .busy_o              (busy),
        .done_o              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit              is_rpl;
        logic [47:0]     tha;
        logic [31:0]     tpa;
        logic [6:0][31:0] w;
    } frame_vec_t;

    frame_vec_t vec [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req"},   64'(req_o), 64'd0);
        chk({tag, "_wld"},   64'(wld),   64'd0);
        chk({tag, "_data"},  64'(data),  64'd0);
        chk({tag, "_be"},    64'(be),    64'd0);
        chk({tag, "_tlast"}, 64'(tlast), 64'd0);
        chk({tag, "_busy"},  64'(busy),  64'd0);
        chk({tag, "_done"},  64'(done),  64'd0);
    endtask

    task automatic trigger(input frame_vec_t v);
        @(negedge clk);
        if (v.is_rpl) begin
            rpl_start = 1'b1;
            rpl_tha   = v.tha;
            rpl_tpa   = v.tpa;
        end else begin
            req_start = 1'b1;
            req_tpa   = v.tpa;
        end
        @(negedge clk);
        req_start = 1'b0;
        rpl_start = 1'b0;
        // scramble the trigger fields: the frame must use the sampled copy
        req_tpa   = '1;
        rpl_tha   = '1;
        rpl_tpa   = '1;
    endtask

    // Waits for the arbiter request, grants after gnt_delay cycles, collects
    // the frame under the chosen ready pattern and checks the DONE cycle.
    task automatic serve_frame(input string tag, input frame_vec_t v, input bit bp,
                               input int gnt_delay, input bit pulse_at_done,
                               input logic [31:0] done_tpa);
        int n;
        int got;
        int cyc;
        logic [31:0] ew;
        logic [3:0]  eb;
        logic [3:0]  pat;
        pat = 4'b1001;   // ready sequence 1,0,0,1 (bit 0 first)
        n = 0;
        while (!req_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_rise"}, 64'(req_o), 64'd1);
        if (!req_o) return;
        chk({tag, "_arb_wld"},  64'(wld),  64'd0);
        chk({tag, "_arb_busy"}, 64'(busy), 64'd1);
        repeat (gnt_delay) @(negedge clk);
        chk({tag, "_arb_hold"}, 64'(req_o), 64'd1);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;   // dropping the grant during SEND must not stall
        chk({tag, "_first_word_wld"}, 64'(wld), 64'd1);
        got = 0;
        cyc = 0;
        while (got < NW && cyc < 100) begin
            ready = bp ? pat[cyc[1:0]] : 1'b1;
            ew = (got < 7) ? v.w[got] : 32'd0;
            eb = (got == NW - 1) ? LAST_BE : 4'b1111;
            if (!wld) begin
                chk({tag, "_wld_held"}, 64'(wld), 64'd1);
            end else if (ready) begin
                chk($sformatf("%s_w%0d_data", tag, got), 64'(data), 64'(ew));
                chk($sformatf("%s_w%0d_be", tag, got), 64'(be), 64'(eb));
                chk($sformatf("%s_w%0d_tlast", tag, got), 64'(tlast), 64'(got == NW - 1));
                chk($sformatf("%s_w%0d_req", tag, got), 64'(req_o), 64'd1);
                got++;
            end else begin
                chk($sformatf("%s_stall%0d_data", tag, got), 64'(data), 64'(ew));
                chk($sformatf("%s_stall%0d_tlast", tag, got), 64'(tlast), 64'(got == NW - 1));
            end
            cyc++;
            @(negedge clk);
        end
        ready = 1'b0;
        chk({tag, "_beats"}, 64'(got), 64'(NW));
        if (!bp) chk({tag, "_consecutive"}, 64'(cyc), 64'(NW));
        chk({tag, "_done_pulse"}, 64'(done),  64'd1);
        chk({tag, "_done_req"},   64'(req_o), 64'd0);
        chk({tag, "_done_wld"},   64'(wld),   64'd0);
        if (pulse_at_done) begin
            req_start = 1'b1;
            req_tpa   = done_tpa;
        end
        @(negedge clk);
        req_start = 1'b0;
        req_tpa   = '1;
        chk({tag, "_done_width"}, 64'(done), 64'd0);
        $display("frame %s: kind=%s tpa=%h beats=%0d cycles=%0d", tag,
                 v.is_rpl ? "reply" : "request", v.tpa, got, cyc);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        our_mac   = 48'h000A_3501_0203;
        our_ip    = 32'hC0A8_0002;
        req_start = 1'b0;
        req_tpa   = '0;
        rpl_start = 1'b0;
        rpl_tha   = '0;
        rpl_tpa   = '0;
        gnt       = 1'b0;
        ready     = 1'b0;

        // request C0A80001
        vec[0].is_rpl = 1'b0; vec[0].tha = '0; vec[0].tpa = 32'hC0A8_0001;
        vec[0].w[0] = 32'h0001_0800; vec[0].w[1] = 32'h0604_0001;
        vec[0].w[2] = 32'h000A_3501; vec[0].w[3] = 32'h0203_C0A8;
        vec[0].w[4] = 32'h0002_0000; vec[0].w[5] = 32'h0000_0000;
        vec[0].w[6] = 32'hC0A8_0001;
        // reply to 1122_3344_5566 / C0A80064
        vec[1].is_rpl = 1'b1; vec[1].tha = 48'h1122_3344_5566; vec[1].tpa = 32'hC0A8_0064;
        vec[1].w[0] = 32'h0001_0800; vec[1].w[1] = 32'h0604_0002;
        vec[1].w[2] = 32'h000A_3501; vec[1].w[3] = 32'h0203_C0A8;
        vec[1].w[4] = 32'h0002_1122; vec[1].w[5] = 32'h3344_5566;
        vec[1].w[6] = 32'hC0A8_0064;
        // request 0A000001
        vec[2].is_rpl = 1'b0; vec[2].tha = '0; vec[2].tpa = 32'h0A00_0001;
        vec[2].w[0] = 32'h0001_0800; vec[2].w[1] = 32'h0604_0001;
        vec[2].w[2] = 32'h000A_3501; vec[2].w[3] = 32'h0203_C0A8;
        vec[2].w[4] = 32'h0002_0000; vec[2].w[5] = 32'h0000_0000;
        vec[2].w[6] = 32'h0A00_0001;
        // reply to broadcast-like all-ones MAC / 01020304
        vec[3].is_rpl = 1'b1; vec[3].tha = 48'hFFFF_FFFF_FFFF; vec[3].tpa = 32'h0102_0304;
        vec[3].w[0] = 32'h0001_0800; vec[3].w[1] = 32'h0604_0002;
        vec[3].w[2] = 32'h000A_3501; vec[3].w[3] = 32'h0203_C0A8;
        vec[3].w[4] = 32'h0002_FFFF; vec[3].w[5] = 32'hFFFF_FFFF;
        vec[3].w[6] = 32'h0102_0304;

        // reset state, with a trigger pulse that reset must swallow
        repeat (2) @(negedge clk);
        req_start = 1'b1;
        req_tpa   = 32'h1234_5678;
        @(negedge clk);
        req_start = 1'b0;
        chk_idle_outputs("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk_idle_outputs("post_reset");

        // table-driven frames: alternate full-rate and 1,0,0,1 backpressure
        for (int i = 0; i < 4; i++) begin
            trigger(vec[i]);
            serve_frame($sformatf("tbl%0d", i), vec[i], (i % 2) == 1, 3, 1'b0, 32'd0);
        end

        // simultaneous triggers: reply goes first, request after DONE
        @(negedge clk);
        req_start = 1'b1; req_tpa = vec[0].tpa;
        rpl_start = 1'b1; rpl_tha = vec[1].tha; rpl_tpa = vec[1].tpa;
        @(negedge clk);
        req_start = 1'b0; rpl_start = 1'b0;
        req_tpa = '1; rpl_tha = '1; rpl_tpa = '1;
        serve_frame("simul_rpl", vec[1], 1'b0, 3, 1'b0, 32'd0);
        serve_frame("simul_req", vec[0], 1'b1, 1, 1'b0, 32'd0);

        // repeat request pulse before transmission overwrites its fields
        @(negedge clk);
        rpl_start = 1'b1; rpl_tha = vec[3].tha; rpl_tpa = vec[3].tpa;
        req_start = 1'b1; req_tpa = vec[0].tpa;
        @(negedge clk);
        rpl_start = 1'b0; rpl_tha = '1; rpl_tpa = '1;
        req_tpa = vec[2].tpa;
        @(negedge clk);
        req_start = 1'b0; req_tpa = '1;
        serve_frame("ovr_rpl", vec[3], 1'b0, 2, 1'b0, 32'd0);
        serve_frame("ovr_req", vec[2], 1'b0, 2, 1'b0, 32'd0);

        // trigger coincident with DONE starts the next frame
        trigger(vec[2]);
        serve_frame("dn_first", vec[2], 1'b0, 3, 1'b1, vec[0].tpa);
        serve_frame("dn_next", vec[0], 1'b0, 3, 1'b0, 32'd0);

        // reset after the third accepted beat aborts the frame
        trigger(vec[0]);
        begin
            int n;
            n = 0;
            while (!req_o && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("abort_req_rise", 64'(req_o), 64'd1);
            gnt = 1'b1;
            @(negedge clk);
            gnt   = 1'b0;
            ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            rpl_start = 1'b1; rpl_tha = vec[1].tha; rpl_tpa = vec[1].tpa;
            @(negedge clk);
            rpl_start = 1'b0;
            chk("abort_w3_data", 64'(data), 64'(vec[0].w[3]));
            rst = 1'b1;
            #1;
            chk_idle_outputs("abort_async");
            @(negedge clk);
            chk_idle_outputs("abort_hold");
            rst   = 1'b0;
            ready = 1'b0;
            n = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (req_o || done) n++;
            end
            chk("abort_pending_dropped", 64'(n), 64'd0);
            $display("abort: reset after 3 beats, outputs cleared");
        end
        trigger(vec[0]);
        serve_frame("after_abort", vec[0], 1'b0, 3, 1'b0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/arp_tx.md
ARP_TX -- requirements
Module: arp_tx

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows:
  - clk_user_i  in  1  user clock; all logic on the rising edge.
  - reset_i  in  1  asynchronous, active-high reset.
REQ-002 Control ports:
  - our_mac_i  in  48  local MAC, SHA field.
  - our_ip_i  in  32  local IP, SPA field.
REQ-003 Request trigger ports:
  - req_start_i  in  1  one-cycle pulse, send ARP request.
  - req_tpa_i  in  32  IP to resolve; sampled with req_start_i.
REQ-004 Reply trigger ports:
  - rpl_start_i  in  1  one-cycle pulse, send ARP reply.
  - rpl_tha_i  in  48  requester MAC; sampled with rpl_start_i.
  - rpl_tpa_i  in  32  requester IP; sampled with rpl_start_i.
REQ-005 Arbiter and stream ports:
  - tx_arp_req_o  out  1  request to arbiter.
  - tx_arp_gnt_i  in  1  grant from arbiter.
  - tx_arp_data_wld_o  out  1  data word valid.
  - tx_arp_data_ready_i  in  1  sink ready.
  - tx_arp_data_o  out  32  payload word, first byte in [31:24].
  - tx_arp_data_be_o  out  4  byte enables, bit 3 = [31:24].
  - tx_arp_data_tlast_o  out  1  last word of frame.
REQ-006 Status ports:
  - busy_o  out  1  high when state is not IDLE.
  - done_o  out  1  one-cycle pulse after the last word is accepted.

Function
REQ-007 The state machine SHALL have four states: IDLE, ARB, SEND and DONE.
  - IDLE->ARB when a pending frame exists.
  - ARB->SEND on tx_arp_gnt_i=1.
  - SEND->DONE on the accepted beat with tlast.
  - DONE->IDLE after one cycle.
REQ-008 Each trigger type SHALL have a one-deep pending register that captures its fields whenever the start pulse is seen, in any state.
  - A repeat pulse before transmission overwrites the fields.
  - Pending is cleared when the frame is selected in IDLE.
REQ-009 When both types are pending in IDLE, the reply SHALL be selected first; the request follows after DONE.
REQ-010 Frame fields SHALL be latched into a frame register at IDLE->ARB and held for the whole frame, including our_mac_i and our_ip_i.
REQ-011 tx_arp_req_o SHALL be registered, asserted from ARB entry through SEND, and deasserted in DONE.
REQ-012 tx_arp_data_wld_o SHALL be asserted only in SEND.
  - The word index advances only on a beat where wld=1 and ready=1.
  - data, be and tlast are held stable while wld=1 and ready=0.
REQ-013 Frame words, in order:
  - W0 = 0001_0800.
  - W1 = 06_04 followed by oper: 0001 for a request, 0002 for a reply.
  - W2 = SHA[47:16].
  - W3 = {SHA[15:0], SPA[31:16]}.
  - W4 = {SPA[15:0], THA[47:32]}.
  - W5 = THA[31:0].
  - W6 = TPA.
  - THA = 0 for a request.
REQ-014 Without padding, the frame SHALL be 7 words, all with be=1111, and tlast on W6.
REQ-015 The first word SHALL be presented in the cycle after the grant is sampled.
  - With ready held high, 7 words are sent in 7 consecutive cycles.
REQ-016 tx_arp_gnt_i SHALL be ignored outside ARB.
  - Deassertion of gnt during SEND does not stall or abort the frame.
REQ-017 A trigger pulse coincident with DONE SHALL be captured and SHALL start the next frame from IDLE.

Reset
REQ-018 While reset_i=1, all outputs SHALL be 0, the state SHALL be IDLE, and pending registers and the word index SHALL be cleared.
REQ-019 Reset asserted mid-frame SHALL abort the frame immediately, with no tlast and no done_o; pending triggers are discarded.

Configuration
REQ-020 With macro ARP_TX_PAD_EN defined, the frame SHALL be padded to the 46-byte Ethernet minimum.
  - W7..W10 = 0 with be=1111.
  - W11 = 0 with be=1100 and tlast.
  - Total 12 words.
REQ-021 With ARP_TX_PAD_EN undefined, the frame SHALL be 7 words per REQ-014, and no pad logic SHALL be present.

Verification
Common setup: our_mac=000A_3501_0203, our_ip=C0A8_0002.
REQ-022 Request: req_start with tpa=C0A8_0001, gnt after 3 cycles, ready=1 -> req_o rises; words are:
  - 00010800, 06040001, 000A3501, 0203C0A8, 00020000, 00000000, C0A80001.
  - tlast on word 7, done_o one cycle later.
REQ-023 Reply: rpl_start with tha=1122_3344_5566 and tpa=C0A8_0064 -> W1=06040002, W4=00021122, W5=33445566, W6=C0A80064.
REQ-024 Simultaneous req_start and rpl_start in IDLE -> reply frame is sent first, then request frame, with req_o dropping for the DONE cycle between them.
REQ-025 Backpressure: ready toggled 1,0,0,1 repeatedly -> data held stable during stalls; exactly 7 accepted beats; no word is skipped or repeated.
REQ-026 reset_i pulsed after the 3rd accepted beat -> all outputs 0 next cycle, no done_o; a fresh req_start yields a full frame starting at W0.
REQ-027 With ARP_TX_PAD_EN: request frame -> 12 beats, W7..W11=0, W11 be=1100 and tlast.
